// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

   localparam int unsigned TUSER_FRAME_ERR  = 0;
   localparam int unsigned TUSER_PARITY_ERR = 1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: flags the middle and the end of each serial bit period.
module uart_bit_timer #(
   parameter int unsigned CYCLES_PER_BIT = 434
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic half_tick,
   output logic full_tick
);

   localparam int unsigned CNT_W = $clog2(CYCLES_PER_BIT);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (restart || full_tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign half_tick = (cnt_q == CNT_W'(CYCLES_PER_BIT / 2 - 1));
   assign full_tick = (cnt_q == CNT_W'(CYCLES_PER_BIT - 1));

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with AXI-stream output and one-word holding register.
// Optional parity bit checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int unsigned CYCLES_PER_BIT = 434,
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned PARITY_ODD     = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx,
   output logic                  overflow,
   input  logic                  tready,
   output logic                  tvalid,
   output logic [DATA_WIDTH-1:0] tdata,
   output logic [1:0]            tuser
);

   localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

   if (CYCLES_PER_BIT < 4 || DATA_WIDTH < 5 || DATA_WIDTH > 9 || PARITY_ODD > 1) begin : g_param_check
      $error("uart_rx_cfg: unsupported parameter value");
   end

   logic [1:0]            sync_q;
   logic                  rx_s;
   rx_state_t             state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  tvalid_q, tvalid_d;
   logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
   logic [1:0]            tuser_q, tuser_d;
   logic                  overflow_q, overflow_d;
   logic                  restart_c;
   logic                  stop_done_c;
   logic                  half_tick, full_tick;
`ifdef UART_RX_PARITY_EN
   logic                  parity_err_q, parity_err_d;
`endif

   assign rx_s = sync_q[1];

   uart_bit_timer #(
      .CYCLES_PER_BIT(CYCLES_PER_BIT)
   ) u_bit_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .restart  (restart_c),
      .half_tick(half_tick),
      .full_tick(full_tick)
   );

   // Frame sequencing and output holding register.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      restart_c   = 1'b0;
      stop_done_c = 1'b0;
      tvalid_d    = tvalid_q & ~tready;
      tdata_d     = tdata_q;
      tuser_d     = tuser_q;
      overflow_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d = parity_err_q;
`endif

      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d   = START;
               restart_c = 1'b1;
            end
         end
         START: begin
            if (half_tick) begin
               if (!rx_s) begin
                  state_d   = DATA;
                  idx_d     = '0;
                  restart_c = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (full_tick) begin
               shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
               if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                  idx_d = '0;
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (full_tick) begin
               parity_err_d = ((^shift_q) ^ rx_s) != 1'(PARITY_ODD);
               state_d      = STOP;
            end
         end
`endif
         STOP: begin
            // Leave on the mid-bit sample so a back-to-back start bit is seen.
            if (full_tick) begin
               stop_done_c = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (stop_done_c) begin
         if (!tvalid_q || tready) begin
            tvalid_d                  = 1'b1;
            tdata_d                   = shift_q;
            tuser_d[TUSER_FRAME_ERR]  = ~rx_s;
`ifdef UART_RX_PARITY_EN
            tuser_d[TUSER_PARITY_ERR] = parity_err_q;
`else
            tuser_d[TUSER_PARITY_ERR] = 1'b0;
`endif
         end else begin
            overflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q     <= 2'b11;
         state_q    <= IDLE;
         idx_q      <= '0;
         shift_q    <= '0;
         tvalid_q   <= 1'b0;
         tdata_q    <= '0;
         tuser_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         sync_q     <= {sync_q[0], rx};
         state_q    <= state_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         tvalid_q   <= tvalid_d;
         tdata_q    <= tdata_d;
         tuser_q    <= tuser_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         parity_err_q <= 1'b0;
      end else begin
         parity_err_q <= parity_err_d;
      end
   end
`endif

   assign tvalid   = tvalid_q;
   assign tdata    = tdata_q;
   assign tuser    = tuser_q;
   assign overflow = overflow_q;

endmodule
